// File: rtl/multi_core_nonce_dispatcher_if.sv
// Bus between the nonce dispatcher and its array of SHA cores.
// Every core has a start pulse and a nonce going out, and a done pulse and a hash coming back.
interface multi_core_nonce_dispatcher_if #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32,
  parameter int HASH_W    = 256
);
  logic [NUM_CORES-1:0]         core_start;
  logic [NUM_CORES*NONCE_W-1:0] core_nonce;
  logic [NUM_CORES-1:0]         core_done;
  logic [NUM_CORES*HASH_W-1:0]  core_hash;

  modport master (
    output core_start,
    output core_nonce,
    input  core_done,
    input  core_hash
  );

  modport slave (
    input  core_start,
    input  core_nonce,
    output core_done,
    output core_hash
  );
endinterface

// File: rtl/multi_core_nonce_dispatcher.sv
// Round-robin nonce dispatcher over NUM_CORES SHA cores, with a target compare and a found/exhausted report.
// Optional macro HASH_COUNT_EN adds a saturating hash_count output that counts accepted results.
module multi_core_nonce_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32,
  parameter int HASH_W    = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [HASH_W-1:0]             target,
  multi_core_nonce_dispatcher_if.master coreBus,
  output logic                          busy,
  output logic                          found,
  output logic [NONCE_W-1:0]            found_nonce,
  output logic                          exhausted
`ifdef HASH_COUNT_EN
  ,
  output logic [31:0]                   hash_count
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } state_t;

  state_t                             stateR;
  logic [HASH_W-1:0]                  targetR;
  logic [NONCE_W-1:0]                 counterR;
  logic                               spentR;
  logic [NUM_CORES-1:0]               coreBusyR;
  logic [NUM_CORES-1:0]               coreStartR;
  logic [NUM_CORES-1:0][NONCE_W-1:0]  coreNonceR;
  logic                               busyR;
  logic                               foundR;
  logic [NONCE_W-1:0]                 foundNonceR;
  logic                               exhaustedR;

  logic [NUM_CORES-1:0] doneAcc;
  logic [NUM_CORES-1:0] hashValid;
  logic [NUM_CORES-1:0] coreBusyNext;
  logic [IDX_W-1:0]     freeIdx;
  logic [IDX_W-1:0]     winIdx;
  logic                 haveFree;
  logic                 anyValid;
  logic                 dispatch;
  logic                 spentAll;

  // Accepted results, lowest-index winner and free core, and next per-core busy flags
  always_comb begin
    doneAcc   = coreBus.core_done & coreBusyR & {NUM_CORES{stateR == RUN}};
    hashValid = '0;
    freeIdx   = '0;
    winIdx    = '0;
    haveFree  = 1'b0;
    anyValid  = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      hashValid[i] = doneAcc[i] & (coreBus.core_hash[i*HASH_W +: HASH_W] < targetR);
      winIdx       = hashValid[i] ? IDX_W'(i) : winIdx;
      anyValid     = anyValid | hashValid[i];
      freeIdx      = coreBusyR[i] ? freeIdx : IDX_W'(i);
      haveFree     = haveFree | ~coreBusyR[i];
    end
    dispatch     = (stateR == RUN) & ~abort & ~anyValid & ~spentR & haveFree;
    // A dispatch in the same cycle as a done on that core leaves the core busy
    coreBusyNext = (coreBusyR & ~coreBus.core_done)
                 | (dispatch ? (NUM_CORES'(1'b1) << freeIdx) : {NUM_CORES{1'b0}});
    spentAll     = spentR & (coreBusyNext == {NUM_CORES{1'b0}});
  end

  // Search state machine with registered core-side and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR      <= IDLE;
      targetR     <= '0;
      counterR    <= '0;
      spentR      <= 1'b0;
      coreBusyR   <= '0;
      coreStartR  <= '0;
      coreNonceR  <= '0;
      busyR       <= 1'b0;
      foundR      <= 1'b0;
      foundNonceR <= '0;
      exhaustedR  <= 1'b0;
    end else begin
      coreStartR <= '0;
      coreBusyR  <= coreBusyNext;
      if (abort) begin
        stateR      <= IDLE;
        coreBusyR   <= '0;
        busyR       <= 1'b0;
        foundR      <= 1'b0;
        foundNonceR <= '0;
        exhaustedR  <= 1'b0;
      end else begin
        case (stateR)
          RUN: begin
            if (anyValid) begin
              stateR      <= FOUND;
              foundR      <= 1'b1;
              foundNonceR <= coreNonceR[winIdx];
              busyR       <= 1'b0;
            end else if (dispatch) begin
              coreStartR[freeIdx] <= 1'b1;
              coreNonceR[freeIdx] <= counterR;
              // The counter parks at its maximum; spentR marks the space as used up
              if (counterR == {NONCE_W{1'b1}}) begin
                spentR <= 1'b1;
              end else begin
                counterR <= counterR + NONCE_W'(1'b1);
              end
            end else if (spentAll) begin
              stateR     <= EXHAUSTED;
              exhaustedR <= 1'b1;
              busyR      <= 1'b0;
            end else begin
              stateR <= RUN;
            end
          end
          IDLE, FOUND, EXHAUSTED: begin
            if (start) begin
              stateR      <= RUN;
              targetR     <= target;
              counterR    <= '0;
              spentR      <= 1'b0;
              busyR       <= 1'b1;
              foundR      <= 1'b0;
              foundNonceR <= '0;
              exhaustedR  <= 1'b0;
            end else begin
              stateR <= stateR;
            end
          end
          default: begin
            stateR <= IDLE;
            busyR  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign coreBus.core_start = coreStartR;
  assign coreBus.core_nonce = coreNonceR;
  assign busy               = busyR;
  assign found              = foundR;
  assign found_nonce        = foundNonceR;
  assign exhausted          = exhaustedR;

`ifdef HASH_COUNT_EN
  logic [31:0] hashCountR;
  logic [4:0]  doneCount;
  logic [32:0] countSum;

  // Number of results accepted this cycle and the widened running sum
  always_comb begin
    doneCount = 5'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      doneCount = doneCount + {4'd0, doneAcc[i]};
    end
    countSum = {1'b0, hashCountR} + {28'd0, doneCount};
  end

  // Saturating count of accepted results, cleared when a search starts or is aborted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hashCountR <= 32'd0;
    end else if (abort) begin
      hashCountR <= 32'd0;
    end else if (stateR != RUN && start) begin
      hashCountR <= 32'd0;
    end else if (stateR == RUN) begin
      hashCountR <= countSum[32] ? 32'hFFFF_FFFF : countSum[31:0];
    end else begin
      hashCountR <= hashCountR;
    end
  end

  assign hash_count = hashCountR;
`endif

endmodule

// File: tb/tb_multi_core_nonce_dispatcher.sv
// Scoreboard bench for multi_core_nonce_dispatcher with two cores and 4-bit nonces; the core models
// reply after a fixed latency, and a monitor checks every dispatch and the found/exhausted outcome.
module tb_multi_core_nonce_dispatcher;
  localparam int NC  = 2;
  localparam int NW  = 4;
  localparam int HW  = 16;
  localparam int LAT = 3;

  typedef struct {
    bit         isFound;
    logic [3:0] nonce;
  } outcome_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [HW-1:0] target;
  logic          busy;
  logic          found;
  logic [NW-1:0] foundNonce;
  logic          exhausted;
`ifdef HASH_COUNT_EN
  logic [31:0]   hashCount;
`endif

  multi_core_nonce_dispatcher_if #(.NUM_CORES(NC), .NONCE_W(NW), .HASH_W(HW)) coreBus ();

  multi_core_nonce_dispatcher #(.NUM_CORES(NC), .NONCE_W(NW), .HASH_W(HW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .target(target),
    .coreBus(coreBus),
    .busy(busy),
    .found(found),
    .found_nonce(foundNonce),
    .exhausted(exhausted)
`ifdef HASH_COUNT_EN
    ,
    .hash_count(hashCount)
`endif
  );

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  int startCyc = 0;
  int expNonce = 0;
  int dispCount = 0;
  int dispCyc[2];
  int firstNonce = -1;
  int mode = 0;
  int doneCyc[16];
  int lastDoneCyc = 0;
  outcome_t expQ[$];
  outcome_t monO;
  bit       prevFound = 1'b0;
  bit       prevExh = 1'b0;

  bit         active[NC];
  int         rem[NC];
  logic [3:0] nonceOf[NC];
  logic [NC-1:0] readyV;
  logic [NC-1:0] fireV;
  bit         have4;
  bit         have5;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [HW-1:0] hashOf(input int m, input logic [3:0] n);
    case (m)
      0:       hashOf = 16'h0000;
      1:       hashOf = (n == 4'd9) ? 16'h0005 : 16'h0020 + {12'd0, n};
      2:       hashOf = 16'hFFFF;
      3:       hashOf = (n == 4'd4 || n == 4'd5) ? 16'h0001 : 16'h0020 + {12'd0, n};
      default: hashOf = 16'hFFFF;
    endcase
  endfunction

  // SHA core models: reply LAT cycles after start; mode 3 holds nonces 4 and 5 until both can finish together
  initial begin
    coreBus.core_done = '0;
    coreBus.core_hash = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < NC; i++) begin
          active[i] = 1'b0;
          rem[i] = 0;
        end
        coreBus.core_done = '0;
        coreBus.core_hash = '0;
      end else begin
        readyV = '0;
        have4 = 1'b0;
        have5 = 1'b0;
        for (int i = 0; i < NC; i++) begin
          if (active[i]) begin
            if (rem[i] > 0) rem[i]--;
            if (rem[i] == 0) begin
              readyV[i] = 1'b1;
              if (nonceOf[i] == 4'd4) have4 = 1'b1;
              if (nonceOf[i] == 4'd5) have5 = 1'b1;
            end
          end
        end
        for (int i = 0; i < NC; i++) begin
          fireV[i] = readyV[i] && (mode != 3 || !(nonceOf[i] == 4'd4 || nonceOf[i] == 4'd5) || (have4 && have5));
        end
        coreBus.core_done = fireV;
        for (int i = 0; i < NC; i++) begin
          if (fireV[i]) begin
            coreBus.core_hash[i*HW +: HW] = hashOf(mode, nonceOf[i]);
            active[i] = 1'b0;
            doneCyc[nonceOf[i]] = cyc;
            lastDoneCyc = cyc;
          end else begin
            coreBus.core_hash[i*HW +: HW] = '0;
          end
        end
        for (int i = 0; i < NC; i++) begin
          if (coreBus.core_start[i]) begin
            active[i] = 1'b1;
            rem[i] = LAT;
            nonceOf[i] = coreBus.core_nonce[i*NW +: NW];
          end
        end
      end
    end
  end

  // Monitor: checks every dispatch and pops the expected outcome when found or exhausted rises
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (coreBus.core_start != '0) begin
          chk("dispatch_onehot", $countones(coreBus.core_start), 1);
          for (int i = 0; i < NC; i++) begin
            if (coreBus.core_start[i]) begin
              chk("dispatch_nonce", coreBus.core_nonce[i*NW +: NW], expNonce);
              if (dispCount < 2) dispCyc[dispCount] = cyc;
              if (dispCount == 0) firstNonce = int'(coreBus.core_nonce[i*NW +: NW]);
              dispCount++;
              expNonce++;
            end
          end
        end
        if (found) chk("no_start_after_found", coreBus.core_start, 0);
        if ((found && !prevFound) || (exhausted && !prevExh)) begin
          if (expQ.size() == 0) begin
            chk("unexpected_outcome", 1, 0);
          end else begin
            monO = expQ.pop_front();
            chk("outcome_kind_found", found, monO.isFound);
            chk("outcome_kind_exhausted", exhausted, !monO.isFound);
            if (monO.isFound) begin
              chk("found_nonce", foundNonce, monO.nonce);
              chk("found_latency", cyc - doneCyc[foundNonce], 1);
            end else begin
              chk("exhaust_latency_ok", (cyc - lastDoneCyc >= 1) && (cyc - lastDoneCyc <= 2), 1);
            end
          end
        end
      end
      prevFound = found;
      prevExh = exhausted;
    end
  end

  task automatic doStart(input logic [HW-1:0] t);
    @(negedge clk);
    expNonce = 0;
    dispCount = 0;
    firstNonce = -1;
    target = t;
    start = 1'b1;
    @(posedge clk);
    #1;
    startCyc = cyc;
    start = 1'b0;
  endtask

  task automatic waitOutcome(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic pushExp(input bit f, input logic [3:0] n);
    outcome_t o;
    o.isFound = f;
    o.nonce = n;
    expQ.push_back(o);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_found", found, 0);
    chk("reset_exhausted", exhausted, 0);
    chk("reset_found_nonce", foundNonce, 0);
    chk("reset_core_start", coreBus.core_start, 0);
    chk("reset_core_nonce", coreBus.core_nonce, 0);
`ifdef HASH_COUNT_EN
    chk("reset_hash_count", hashCount, 0);
`endif

    // all-ones target, every hash 0: nonce 0 wins
    mode = 0;
    pushExp(1'b1, 4'd0);
    doStart(16'hFFFF);
    chk("busy_in_run", busy, 1);
    waitOutcome("t1");
    chk("t1_first_dispatch_cycle", dispCyc[0], startCyc + 1);
    chk("t1_second_dispatch_cycle", dispCyc[1], startCyc + 2);
    repeat (3) @(negedge clk);
    chk("t1_found_held", found, 1);
    chk("t1_found_nonce_held", foundNonce, 0);
    chk("t1_busy_after_found", busy, 0);
`ifdef HASH_COUNT_EN
    chk("t1_hash_count", hashCount, 1);
`endif
    repeat (8) @(negedge clk);

    // target 0x10, only nonce 9 hashes below it
    mode = 1;
    pushExp(1'b1, 4'd9);
    doStart(16'h0010);
    waitOutcome("t2");
    repeat (8) @(negedge clk);
    chk("t2_found_nonce_held", foundNonce, 9);

    // nothing hashes below the target: the whole space is walked once
    mode = 2;
    pushExp(1'b0, 4'd0);
    doStart(16'h0010);
    waitOutcome("t3");
    repeat (4) @(negedge clk);
    chk("t3_dispatch_count", dispCount, 16);
    chk("t3_found", found, 0);
    chk("t3_exhausted_held", exhausted, 1);
    chk("t3_busy", busy, 0);
`ifdef HASH_COUNT_EN
    chk("t3_hash_count", hashCount, 16);
`endif
    repeat (4) @(negedge clk);

    // nonces 4 and 5 both valid in the same cycle: lower core index wins
    mode = 3;
    pushExp(1'b1, 4'd4);
    doStart(16'h0010);
    waitOutcome("t4");
    repeat (8) @(negedge clk);

    // abort while both cores are busy: their valid results must be ignored
    mode = 0;
    doStart(16'hFFFF);
    repeat (3) @(negedge clk);
    chk("t5_busy_before_abort", busy, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("t5_busy_after_abort", busy, 0);
    repeat (10) @(negedge clk);
    chk("t5_found_after_abort", found, 0);
    chk("t5_exhausted_after_abort", exhausted, 0);
`ifdef HASH_COUNT_EN
    chk("t5_hash_count", hashCount, 0);
`endif

    // abort beats start in the same cycle
    @(negedge clk);
    dispCount = 0;
    target = 16'hFFFF;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_dispatch_count", dispCount, 0);

    // asynchronous reset in the middle of a search, then a fresh search from nonce 0
    mode = 0;
    doStart(16'hFFFF);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_found", found, 0);
    chk("t7_rst_exhausted", exhausted, 0);
    chk("t7_rst_core_start", coreBus.core_start, 0);
    chk("t7_rst_core_nonce", coreBus.core_nonce, 0);
    @(negedge clk);
    rst = 1'b0;
    pushExp(1'b1, 4'd0);
    doStart(16'hFFFF);
    waitOutcome("t7");
    chk("t7_restart_nonce", firstNonce, 0);
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
